// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, state encoding and parity helper for the PS/2 key sender
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: serializes one byte as an 11-bit PS/2 device-to-host frame
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_done
);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  state_t state, state_n;
  logic [15:0] cnt;
  logic [3:0] idx;
  logic [10:0] sh;
  logic half_end;
  // next-state and outputs; data comes straight from the shift register so it only moves on a low->high step
  always_comb begin
    half_end = cnt == HALF_LAST;
    state_n = (state == IDLE && start) ? BIT_HI :
              (state == BIT_HI && half_end) ? BIT_LO :
              (state == BIT_LO && half_end) ? (idx < LAST_BIT ? BIT_HI : IDLE) : state;
    frame_done = state == BIT_LO && half_end && idx == LAST_BIT;
    ps2_clk = state != BIT_LO;
    ps2_data = state == IDLE ? 1'b1 : sh[0];
  end
  // state, half-period counter (cleared on every state change) and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;
      if (state == IDLE && start) begin
        sh <= {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
        idx <= '0;
      end else if (state == BIT_LO && half_end && state_n == BIT_HI) begin
        sh <= sh >> 1;
        idx <= idx + 4'd1;
      end
    end
  end
endmodule

// File: rtl/ps2_key_sender.sv
// ps2_key_sender: sends a key's make (and optional break) byte sequence as PS/2 frames with idle gaps
module ps2_key_sender
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       brk_en,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [15:0] gap_cnt;
  logic [7:0] code_q, tx_byte;
  logic brk_q, start, frame_done, gap_end, more;
  logic [1:0] byte_idx;
  // sequencing: BIT_HI here stands for a whole frame in flight, the serializer owns the bit phases
  always_comb begin
    key_ready = state == IDLE;
    busy = !key_ready;
    gap_end = state == GAP && gap_cnt == GAP_LAST;
    more = brk_q && byte_idx != 2'd2;
    start = (key_valid && key_ready && key_code != PS2_BREAK) || (gap_end && more);
    tx_byte = key_ready ? key_code : (byte_idx == 2'd0 ? PS2_BREAK : code_q);
    done = gap_end && !more;
    state_n = (state == IDLE && start) ? BIT_HI :
              (state == BIT_HI && frame_done) ? GAP :
              gap_end ? (more ? BIT_HI : IDLE) : state;
  end
  // state, gap counter and captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      code_q <= '0;
      brk_q <= 1'b0;
      byte_idx <= '0;
    end else begin
      state <= state_n;
      gap_cnt <= (state == GAP && state_n == GAP) ? gap_cnt + 16'd1 : '0;
      if (state == IDLE && start) begin
        code_q <= key_code;
        brk_q <= brk_en;
        byte_idx <= '0;
      end else if (gap_end && more) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end
  ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_byte(tx_byte),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .frame_done(frame_done)
  );
endmodule

// File: tb/tb_ps2_key_sender.sv
// tb_ps2_key_sender: randomized self-checking bench against a frame-level reference model
module tb_ps2_key_sender;
  localparam int CLK_DIV = 4;
  localparam int GAP = 8;
  localparam int SEQ1 = 22 * CLK_DIV + GAP;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, brk_en = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic key_ready, ps2_clk, ps2_data, busy, done;
  int n_cmp = 0, n_bad = 0, cyc = 0, unstable = 0;
  logic prev_clk = 1'b1, prev_data = 1'b1;
  logic bits[$];
  int acc_q[$], done_q[$];

  ps2_key_sender #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .brk_en(brk_en),
    .key_ready(key_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_clk && !ps2_clk) begin
        bits.push_back(ps2_data);
        if (ps2_data !== prev_data) unstable++;
      end
      if (key_valid && key_ready) acc_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [65:0] model(input logic [7:0] seq[$]);
    logic [65:0] v;
    int k, ones;
    v = '0;
    k = 0;
    foreach (seq[j]) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(seq[j][i]);
      v[k] = 1'b0;
      for (int i = 0; i < 8; i++) v[k + 1 + i] = seq[j][i];
      v[k + 9] = (ones % 2) == 0;
      v[k + 10] = 1'b1;
      k += 11;
    end
    return v;
  endfunction

  function automatic logic [65:0] packed_bits();
    logic [65:0] v;
    v = '0;
    foreach (bits[i]) if (i < 66) v[i] = bits[i];
    return v;
  endfunction

  function automatic int latency(input int n);
    return (done_q.size() > n && acc_q.size() > n) ? done_q[n] - acc_q[n] : -1;
  endfunction

  task automatic clear();
    bits.delete();
    acc_q.delete();
    done_q.delete();
    unstable = 0;
  endtask

  task automatic request(input logic [7:0] code, input logic brk);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!key_ready && t < 2000);
    key_valid = 1'b1;
    key_code = code;
    brk_en = brk;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code = 8'($urandom);
    brk_en = 1'($urandom);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_q.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({key_ready, busy, ps2_clk, ps2_data, done} !== 5'b10110) begin
      n_bad++;
      $display("FAIL reset_hold got rdy/busy/clk/data/done=%b expected 10110", {key_ready, busy, ps2_clk, ps2_data, done});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({key_ready, busy, ps2_clk, ps2_data, done} !== 5'b10110) begin
      n_bad++;
      $display("FAIL reset_release got rdy/busy/clk/data/done=%b expected 10110", {key_ready, busy, ps2_clk, ps2_data, done});
    end
  endtask

  task automatic test_make();
    logic [7:0] q[$];
    clear();
    q = {8'h1C};
    request(8'h1C, 1'b0);
    wait_done(1);
    n_cmp++;
    if (bits.size() != 11 || packed_bits() !== model(q)) begin
      n_bad++;
      $display("FAIL make_bits got %h (%0d bits) expected %h", packed_bits(), bits.size(), model(q));
    end
    n_cmp++;
    if (done_q.size() != 1 || latency(0) != SEQ1) begin
      n_bad++;
      $display("FAIL make_latency got %0d (dones=%0d) expected %0d", latency(0), done_q.size(), SEQ1);
    end
  endtask

  task automatic test_break();
    logic [7:0] q[$];
    clear();
    q = {8'h1C, 8'hF0, 8'h1C};
    request(8'h1C, 1'b1);
    wait_done(1);
    n_cmp++;
    if (bits.size() != 33 || packed_bits() !== model(q)) begin
      n_bad++;
      $display("FAIL break_bits got %h (%0d bits) expected %h", packed_bits(), bits.size(), model(q));
    end
    n_cmp++;
    if (done_q.size() != 1 || latency(0) != 3 * SEQ1) begin
      n_bad++;
      $display("FAIL break_latency got %0d (dones=%0d) expected %0d", latency(0), done_q.size(), 3 * SEQ1);
    end
  endtask

  task automatic test_zero();
    logic [7:0] q[$];
    clear();
    q = {8'h00};
    request(8'h00, 1'b0);
    wait_done(1);
    n_cmp++;
    if (bits.size() != 11 || packed_bits() !== model(q)) begin
      n_bad++;
      $display("FAIL zero_bits got %h (%0d bits) expected %h", packed_bits(), bits.size(), model(q));
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++;
      $display("FAIL zero_stability got %0d data changes at falling edges expected 0", unstable);
    end
  endtask

  task automatic test_f0_drop();
    int bad;
    clear();
    bad = 0;
    request(8'hF0, 1'b1);
    repeat (300) begin
      @(negedge clk);
      if (!key_ready || !ps2_clk || !ps2_data || done) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL f0_idle got %0d non-idle cycles expected 0", bad);
    end
    n_cmp++;
    if (bits.size() != 0 || done_q.size() != 0 || acc_q.size() != 1) begin
      n_bad++;
      $display("FAIL f0_drop got bits=%0d dones=%0d accepts=%0d expected 0/0/1", bits.size(), done_q.size(), acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] code;
    logic [7:0] q[$];
    int t;
    clear();
    code = 8'($urandom);
    if (code == 8'hF0) code = 8'h1D;
    request(code, 1'($urandom));
    t = 0;
    while (bits.size() < 4 && t < 500) begin
      @(negedge clk);
      t++;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ps2_clk, ps2_data, key_ready, busy} !== 4'b1110 || bits.size() != 4) begin
      n_bad++;
      $display("FAIL midreset got clk/data/rdy/busy=%b falls=%0d expected 1110 falls=4", {ps2_clk, ps2_data, key_ready, busy}, bits.size());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear();
    code = 8'($urandom);
    if (code == 8'hF0) code = 8'h2A;
    q = {code};
    request(code, 1'b0);
    wait_done(1);
    n_cmp++;
    if (bits.size() != 11 || packed_bits() !== model(q) || latency(0) != SEQ1) begin
      n_bad++;
      $display("FAIL after_reset code %h got %h lat %0d expected %h lat %0d", code, packed_bits(), latency(0), model(q), SEQ1);
    end
  endtask

  task automatic test_random();
    logic [7:0] code;
    logic brk;
    logic [7:0] q[$];
    for (int r = 0; r < 4; r++) begin
      clear();
      code = 8'($urandom);
      if (code == 8'hF0) code = 8'h0F;
      brk = 1'($urandom);
      q = brk ? {code, 8'hF0, code} : {code};
      request(code, brk);
      wait_done(1);
      n_cmp++;
      if (packed_bits() !== model(q) || bits.size() != 11 * q.size() || latency(0) != q.size() * SEQ1 || unstable != 0) begin
        n_bad++;
        $display("FAIL random_%0d code %h brk %b got %h lat %0d unstable %0d expected %h lat %0d", r, code, brk, packed_bits(), latency(0), unstable, model(q), q.size() * SEQ1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int t;
    clear();
    q = {8'h1C, 8'h32};
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!key_ready && t < 2000);
    key_valid = 1'b1;
    key_code = 8'h1C;
    brk_en = 1'b0;
    @(posedge clk);
    #1 key_code = 8'h32;
    t = 0;
    while (acc_q.size() < 2 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    key_valid = 1'b0;
    wait_done(2);
    repeat (4) @(posedge clk);
    n_cmp++;
    if (bits.size() != 22 || packed_bits() !== model(q)) begin
      n_bad++;
      $display("FAIL b2b_bits got %h (%0d bits) expected %h", packed_bits(), bits.size(), model(q));
    end
    n_cmp++;
    if (done_q.size() != 2 || acc_q.size() != 2 || acc_q[1] - done_q[0] != 1) begin
      n_bad++;
      $display("FAIL b2b_gap got dones=%0d accepts=%0d expected 2/2 with 1 ready cycle between", done_q.size(), acc_q.size());
    end
    n_cmp++;
    if (latency(0) != SEQ1 || latency(1) != SEQ1) begin
      n_bad++;
      $display("FAIL b2b_latency got %0d,%0d expected %0d", latency(0), latency(1), SEQ1);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_zero();
    test_f0_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_sender.md
PS2_KEY_SENDER -- requirements
Module: ps2_key_sender

Interface
REQ-001 Parameter CLK_DIV, default 2500: PS/2 clock half-period in clk cycles, which gives 10 kHz at 50 MHz; the legal range is 2..65535.
REQ-002 Parameter GAP_CYCLES, default 5000: idle time in clk cycles after each byte frame; the legal range is 1..65535.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; the block uses this one clock only.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  a key request is present.
- key_code  in  8  PS/2 set-2 scan code of the key.
- brk_en  in  1  1 = send make then break (F0, code); 0 = send make only.
- key_ready  out  1  the block can accept a request.
- ps2_clk  out  1  PS/2 device clock; idle level is 1.
- ps2_data  out  1  PS/2 device data; idle level is 1.
- busy  out  1  a transmission is in progress.
- done  out  1  one-cycle pulse when a key sequence completes.

Function
REQ-004 key_ready SHALL be 1 exactly when the state is IDLE.
REQ-005 A request is accepted on a clk edge where key_valid and key_ready are both 1.
REQ-006 On acceptance, key_code and brk_en SHALL be captured; later changes on these inputs have no effect.
REQ-007 Byte sequence: brk_en=1 gives {code, 8'hF0, code}; brk_en=0 gives {code}.
REQ-008 Frame format: 11 bits in this order:
- start bit 0;
- data bits d0..d7, LSB first;
- odd parity, so the 8 data bits plus parity hold an odd number of 1s;
- stop bit 1.
REQ-009 Each bit SHALL occupy 2*CLK_DIV cycles: ps2_clk=1 for CLK_DIV cycles, then ps2_clk=0 for CLK_DIV cycles.
REQ-010 ps2_data SHALL change only at the start of a ps2_clk-high phase, and SHALL be stable through the following falling edge.
REQ-011 The first bit's high phase SHALL begin on the cycle after acceptance.
REQ-012 After the stop bit's low phase, ps2_clk=1 and ps2_data=1 for GAP_CYCLES cycles; then the next byte starts, or the sequence ends.
REQ-013 States: IDLE, BIT_HI, BIT_LO, GAP. Transitions:
- IDLE->BIT_HI on acceptance;
- BIT_HI->BIT_LO after CLK_DIV cycles;
- BIT_LO->BIT_HI after CLK_DIV cycles if bit index < 10, else BIT_LO->GAP;
- GAP->BIT_HI if bytes remain, else GAP->IDLE.
REQ-014 done SHALL pulse for one cycle on the last GAP cycle of the sequence, so that key_ready rises on the next cycle.
REQ-015 Sequence length SHALL be N*(22*CLK_DIV+GAP_CYCLES) cycles, with N = 3 or 1, counted from the accepting edge to the edge where done is sampled high.
REQ-016 busy SHALL be the complement of key_ready.
REQ-017 key_code=8'hF0 SHALL be accepted and dropped: no frame is sent, done is not pulsed, and the block stays in IDLE.
REQ-018 The half-period counter and the gap counter SHALL be 16 bits wide and reload on every state change; neither counter may wrap.
REQ-019 key_valid held high through done SHALL start a new sequence on the cycle where key_ready=1, with no extra idle cycle.

Reset
REQ-020 While rst=1, the block SHALL immediately and asynchronously force:
- state = IDLE;
- ps2_clk=1, ps2_data=1, done=0, busy=0, key_ready=1;
- all counters and captured registers cleared.
REQ-021 A reset in the middle of a frame SHALL abort the frame without finishing the current bit; the block resumes from IDLE when rst=0.

Structure
REQ-022 Package ps2_pkg SHALL hold:
- PS2_BREAK = 8'hF0;
- PS2_FRAME_BITS = 11;
- the state enum;
- an odd-parity function.
REQ-023 One sub-module, ps2_frame_tx, SHALL serialize a single byte: inputs start and byte; outputs ps2_clk, ps2_data and frame_done. ps2_key_sender SHALL sequence bytes and gaps around it.

Verification
REQ-024 The bench SHALL use CLK_DIV=4 and GAP_CYCLES=8, and SHALL cover these scenarios:
- Code 8'h1C with brk_en=0 -> falling-edge samples 0,0,0,1,1,1,0,0,0,0,1 (the parity bit is 0); done exactly 96 cycles after acceptance.
- Code 8'h1C with brk_en=1 -> three frames; the second frame carries F0 data bits 0,0,0,0,1,1,1,1 with parity 1; done 288 cycles after acceptance.
- Code 8'h00 -> parity 1; check ps2_data is stable across every ps2_clk falling edge.
- Code 8'hF0 -> key_ready stays 1, ps2_clk and ps2_data stay 1 for 300 cycles, no done pulse.
- rst pulsed during the third data bit of a frame -> ps2_clk=1, ps2_data=1 in the same cycle; a new request sent afterwards produces a complete, correct frame.
- key_valid held high continuously -> back-to-back sequences, with key_ready high for one cycle between them; 8'h1C then 8'h32 are both received intact.
